// File: rtl/ahb_lite_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_initiator_if
// Description : Bundle of the request/response handshake and the AHB-Lite
//               bus signals seen by ahb_lite_initiator.
//               modport master : the initiator's view. It takes requests,
//                                returns responses and drives the AHB
//                                address/control/write-data signals.
//               modport slave  : the environment's view. This is the
//                                requester together with the bus
//                                fabric/slave.
// Ports       : req_valid/req_ready/req_write/req_addr/req_size/req_wdata
//               rsp_valid/rsp_rdata/rsp_err
//               HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HRDATA/HREADY
// Revision    : 1.0  initial release
// ============================================================================
interface ahb_lite_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // request side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    // response side
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // AHB-Lite
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HRDATA, HREADY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HRDATA, HREADY
    );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_initiator
// Description : AHB-Lite master. It turns a valid/ready request into one
//               single (non-burst) transfer. Only one transfer is
//               outstanding at a time. Data-phase wait states are bounded
//               by an optional timeout.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-low reset
//               bus    - ahb_lite_initiator_if.master. It carries the
//                        request/response handshake and the AHB-Lite
//                        signals.
// Parameters  : ADDR_W  - address width
//               DATA_W  - data width (32 only)
//               TIMEOUT - max HREADY-low data-phase cycles, 0 disables
// Revision    : 1.0  initial release
// ============================================================================
module ahb_lite_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ahb_lite_initiator_if.master  bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // The counter only needs to reach TIMEOUT. With TIMEOUT=0 it is a
    // harmless saturating bit.
    localparam int              CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam bit              TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] haddr;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [CNT_W-1:0]  wait_cnt;

    logic              accept;
    logic              req_illegal;
    logic              timeout_hit;
    logic              req_ready;
    logic              rsp_valid;
    logic [1:0]        htrans;

    // Size above word, or an address not aligned to the size, is rejected
    // without touching the bus.
    always_comb begin
        req_illegal = 1'b0;
        case (bus.req_size)
            3'd0:    req_illegal = 1'b0;
            3'd1:    req_illegal = bus.req_addr[0];
            3'd2:    req_illegal = (bus.req_addr[1:0] != 2'b00);
            default: req_illegal = 1'b1;
        endcase
    end

    assign accept = bus.req_valid && (state == ST_IDLE);

    // The counter holds the number of HREADY-low cycles already spent in
    // DATA. Timeout fires only in a cycle that is still stalled. If HREADY
    // rises in the cycle the limit is reached, the completion is taken.
    assign timeout_hit = TO_EN && (wait_cnt == CNT_LIMIT) && !bus.HREADY;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        htrans     = HTRANS_IDLE;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = req_illegal ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                htrans = HTRANS_NONSEQ;
                if (bus.HREADY) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.HREADY || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, response registers and data-phase wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            haddr     <= '0;
            hsize     <= '0;
            hwrite    <= 1'b0;
            wdata     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (accept) begin
                haddr    <= bus.req_addr;
                hsize    <= bus.req_size;
                hwrite   <= bus.req_write;
                wdata    <= bus.req_wdata;
                wait_cnt <= '0;
                if (req_illegal) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end

            if (state == ST_DATA) begin
                if (bus.HREADY) begin
                    rsp_rdata <= hwrite ? '0 : bus.HRDATA;
                    rsp_err   <= 1'b0;
                end else begin
                    if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                    if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping. HWDATA always mirrors the captured write data.
    // ------------------------------------------------------------------
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.HADDR     = haddr;
    assign bus.HTRANS    = htrans;
    assign bus.HSIZE     = hsize;
    assign bus.HWRITE    = hwrite;
    assign bus.HWDATA    = wdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_initiator
// Description : Self-checking bench for ahb_lite_initiator (TIMEOUT=4).
//               Expected response timing and values are derived per request
//               from the transfer rules: legality, address-phase waits,
//               data-phase waits and the timeout limit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_lite_initiator;

    localparam int TO = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    ahb_lite_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_lite_initiator #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request, starting from IDLE. The reference model computes:
    //   illegal          -> response 1 cycle after accept, err, rdata 0
    //   legal, waits w   -> NONSEQ for cycles 1..A+1, DATA from cycle A+2
    //     w <= TO        -> response at A+3+w, read data or 0 for writes
    //     w >  TO        -> response at A+3+TO, err, rdata 0
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wd, input int a_w, input int d_w,
                           input logic [31:0] slv_data);
        logic        legal;
        int          rsp_cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        legal = !((size > 3'd2) || (size == 3'd1 && addr[0]) ||
                  (size == 3'd2 && addr[1:0] != 2'b00));
        if (!legal) begin
            rsp_cyc = 1; exp_err = 1'b1; exp_rd = 32'h0;
        end else if (d_w > TO) begin
            rsp_cyc = a_w + 3 + TO; exp_err = 1'b1; exp_rd = 32'h0;
        end else begin
            rsp_cyc = a_w + 3 + d_w; exp_err = 1'b0; exp_rd = wr ? 32'h0 : slv_data;
        end

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wd;
        bus.HRDATA    = slv_data;
        bus.HREADY    = 1'b1;
        check("ready_idle", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        for (int k = 1; k <= rsp_cyc + 1; k++) begin
            if (legal && k <= a_w)
                bus.HREADY = 1'b0;
            else if (legal && k >= a_w + 2 && k < rsp_cyc && (k - (a_w + 2)) < d_w)
                bus.HREADY = 1'b0;
            else
                bus.HREADY = 1'b1;
            @(negedge clk);
            check("htrans", bus.HTRANS, (legal && k <= a_w + 1) ? 2'b10 : 2'b00);
            check("rsp_valid", bus.rsp_valid, (k == rsp_cyc) ? 1 : 0);
            if (legal && k <= a_w + 1) begin
                check("haddr", bus.HADDR, addr);
                check("hwrite", bus.HWRITE, wr);
                check("hsize", bus.HSIZE, size);
            end
            if (legal && wr && k >= a_w + 2 && k < rsp_cyc)
                check("hwdata", bus.HWDATA, wd);
            if (k == rsp_cyc) begin
                check("rsp_err", bus.rsp_err, exp_err);
                check("rsp_rdata", bus.rsp_rdata, exp_rd);
                check("ready_resp", bus.req_ready, 0);
            end
            if (k == rsp_cyc + 1)
                check("ready_after", bus.req_ready, 1);
            @(posedge clk);
            #1;
        end
        bus.HREADY = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        int          r;
        int          accepts;
        int          nons;
        int          rsps;
        int          last_ns;

        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_size  = 3'd0;
        bus.req_wdata = 32'h0;
        bus.HRDATA    = 32'h0;
        bus.HREADY    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_htrans", bus.HTRANS, 0);
        check("rst_haddr", bus.HADDR, 0);
        check("rst_hsize", bus.HSIZE, 0);
        check("rst_hwrite", bus.HWRITE, 0);
        check("rst_hwdata", bus.HWDATA, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_req_ready", bus.req_ready, 1);
        reset = 1'b1;

        // directed cases
        run_txn(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h1234_5678);
        run_txn(1'b0, 32'h0000_0010, 3'd2, 32'h0, 0, 3, 32'hDEAD_BEEF);
        run_txn(1'b0, 32'h0000_0002, 3'd2, 32'h0, 0, 0, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h0000_0010, 3'd3, 32'h0, 0, 0, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h0000_0011, 3'd1, 32'h0, 0, 0, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h0000_0020, 3'd2, 32'h0, 0, 10, 32'h0BAD_0BAD);
        run_txn(1'b0, 32'h0000_0024, 3'd2, 32'h0, 0, 0, 32'h600D_600D);
        run_txn(1'b0, 32'h0000_0028, 3'd2, 32'h0, 1, TO, 32'h5A5A_A5A5);
        run_txn(1'b1, 32'h0000_0013, 3'd0, 32'h0000_00AB, 2, TO + 1, 32'h0);

        // reset in the middle of a stalled data phase
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0040;
        bus.req_size  = 3'd2;
        bus.HREADY    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.HREADY = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("arst_htrans", bus.HTRANS, 0);
        check("arst_req_ready", bus.req_ready, 1);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_haddr", bus.HADDR, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.HREADY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("arst_no_rsp", bus.rsp_valid, 0);
        end
        run_txn(1'b0, 32'h0000_0044, 3'd2, 32'h0, 0, 1, 32'h7777_1111);

        // back-to-back writes with req_valid held
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0100;
        bus.req_size  = 3'd2;
        bus.req_wdata = 32'h1111_0000;
        bus.HREADY    = 1'b1;
        accepts = 0;
        nons    = 0;
        rsps    = 0;
        last_ns = -1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.HTRANS == 2'b10) begin
                if (nons > 0) check("b2b_gap", 64'(c - last_ns), 4);
                last_ns = c;
                nons++;
            end
            if (bus.rsp_valid) rsps++;
            if (bus.req_ready && bus.req_valid) accepts++;
            @(posedge clk);
            #1;
            if (accepts == 3) bus.req_valid = 1'b0;
            bus.req_wdata = bus.req_wdata + 32'h1;
        end
        check("b2b_nonseq", 64'(nons), 3);
        check("b2b_rsp", 64'(rsps), 3);

        // randomized requests
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom % 2);
            r    = int'($urandom_range(0, 7));
            size = (r == 7) ? 3'd3 : 3'(r % 3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 3'd1) addr[0] = 1'b0;
                if (size == 3'd2) addr[1:0] = 2'b00;
            end
            run_txn(wr, addr, size, $urandom, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 6)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_lite_initiator.md
# ahb_lite_initiator

AHB-Lite master that turns a simple valid/ready request port into single, non-burst AHB-Lite transfers. It is the initiator counterpart of the AHB slave interfaces on the SoC bus (RAM and accelerator bridges), and lets a non-CPU agent (test sequencer, DMA front end) drive the same decoder/mux fabric. One transfer is outstanding at a time. Wait states are honoured via HREADY, and a stalled slave is cut off by a timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (only 32 supported)
- TIMEOUT, 16, max HREADY-low cycles in data phase before abort; 0 disables
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_size  in  3  AHB HSIZE encoding (0 byte, 1 half, 2 word)
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  qualifies rsp_valid: alignment error or timeout
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10 only)
- HSIZE  out  3  AHB size
- HWRITE  out  1  AHB direction
- HWDATA  out  DATA_W  AHB write data
- HRDATA  in  DATA_W  AHB read data
- HREADY  in  1  AHB ready from the bus mux

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. All outputs are registered or decoded from state only. There are no combinational paths from HREADY/HRDATA to outputs.
- IDLE:
  - req_ready=1, HTRANS=IDLE.
  - On req_valid&req_ready, capture write/addr/size/wdata.
  - Legality check on capture: size>2, or addr misaligned to size (size1 & addr[0]; size2 & addr[1:0]!=0).
  - Illegal → RESP with err set, no bus transfer.
  - Legal → ADDR.
- ADDR:
  - Drive HTRANS=NONSEQ with captured HADDR/HSIZE/HWRITE.
  - Hold until HREADY=1, then → DATA.
- DATA:
  - HTRANS=IDLE. HWDATA=captured wdata (HWDATA always mirrors the wdata register).
  - On HREADY=1:
    - Read: latch HRDATA into rsp_rdata. Write: rsp_rdata=0.
    - err=0, → RESP.
  - Each HREADY=0 cycle increments wait counter. If TIMEOUT!=0 and counter reaches TIMEOUT: err=1, rsp_rdata=0, → RESP.
  - Counter clears on entry to ADDR.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, → IDLE.
- Outside RESP, rsp_valid=0. rsp_rdata/rsp_err hold their last values.
- HADDR/HSIZE/HWRITE hold captured values in DATA/RESP/IDLE; only HTRANS qualifies them.
- Requests presented while req_ready=0 are ignored (not queued). Requester must hold req_valid.

## Timing
- Reset (async assert, any state):
  - State→IDLE immediately, counter=0.
  - HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 (IDLE).
  - An in-flight transfer is dropped with no response.
- Zero-wait legal transfer, accept at edge 0:
  - ADDR cycle 1 (NONSEQ visible).
  - DATA cycle 2 (HRDATA sampled at edge ending cycle 2).
  - rsp_valid cycle 3.
  - req_ready=1 again cycle 4.
  - Throughput: 1 transfer / 4 cycles.
- N wait states in data phase: rsp_valid at cycle 3+N.
- Illegal request accepted at edge 0: rsp_valid=1, rsp_err=1 in cycle 1. HTRANS never leaves IDLE.
- Timeout:
  - With TIMEOUT=T and HREADY held low, rsp_valid/err asserts T+1 cycles after DATA entry.
  - If HREADY rises in the same cycle the counter hits T, completion wins (err=0).
- NONSEQ is asserted for at least one cycle per legal transfer. NONSEQ is never asserted in DATA or RESP.

## Test plan
- Reset, then write addr 0x0000_0010, size 2, data 0xDEAD_BEEF, HREADY=1: NONSEQ in cycle 1 with HWRITE=1. HWDATA=0xDEAD_BEEF in cycle 2. rsp_valid cycle 3, err=0.
- Read addr 0x0000_0010, slave returns 0xDEAD_BEEF after 3 wait states: rsp_valid at cycle 6, rsp_rdata=0xDEAD_BEEF, err=0.
- Misaligned word read addr 0x0000_0002: rsp_valid cycle 1 with err=1, rsp_rdata=0. HTRANS stays IDLE throughout. Size=3 request gives the same result.
- TIMEOUT=4, read with HREADY stuck low in data phase: rsp_valid/err=1 exactly 5 cycles after DATA entry, then req_ready=1. A following zero-wait read completes normally with err=0.
- Assert reset during DATA with HREADY low: HTRANS=IDLE and req_ready=1 immediately. No rsp_valid is ever emitted for the dropped transfer. Post-reset transfer succeeds.
- Back-to-back: req_valid held high for 3 writes: exactly 3 NONSEQ cycles, spaced 4 cycles apart, and 3 rsp_valid pulses.
